polymem_arbiter: RTL and testbench
==================================

POLYMEM_ARBITER -- requirements
Module: polymem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 7, meaning buffer address width (128 words).
REQ-002 SHALL have parameter DW, default 48, meaning buffer word width.
REQ-003 SHALL have port clk  input  1  single clock for the arbiter and both buffer ports.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports wr_req[i], wr_lock[i]  input  1 each, for i=0,1  write request and burst hold from requester i.
REQ-006 SHALL have ports wr_addr[i]  input  AW  and  wr_data[i]  input  DW  write address and data from requester i.
REQ-007 SHALL have port wr_gnt[i]  output  1  write accepted this cycle for requester i.
REQ-008 SHALL have ports rd_req[i], rd_lock[i]  input  1 each, and rd_addr[i]  input  AW  read request, burst hold and address from requester i.
REQ-009 SHALL have port rd_gnt[i]  output  1  read accepted this cycle for requester i.
REQ-010 SHALL have ports rd_valid[i]  output  1  and  rd_data  output  DW  returned read data, tagged to requester i.
REQ-011 SHALL have buffer-side outputs mem_cea (1), mem_ada (AW), mem_din (DW), mem_ceb (1), mem_oce (1) and mem_adb (AW), plus input mem_dout (DW).

Function
REQ-012 SHALL arbitrate the write port and the read port independently, each with its own round-robin pointer.
REQ-013 SHALL make grants combinational from the same-cycle requests, with at most one wr_gnt and at most one rd_gnt high per cycle.
REQ-014 SHALL resolve a same-cycle request from both requesters in favour of the pointer's requester.
REQ-015 SHALL move the pointer to the other requester after a grant, unless the granted requester's lock is high.
REQ-016 SHALL keep the pointer, while a lock is held, on the locked requester; that requester retains priority even in cycles where it does not request.
REQ-017 SHALL release a lock when lock deasserts, and SHALL ignore a lock from a requester that was not granted.
REQ-018 SHALL set mem_cea = any wr_gnt, and SHALL take mem_ada and mem_din from the granted requester (zero when idle).
REQ-019 SHALL set mem_ceb = any rd_gnt and mem_oce = 1, and SHALL take mem_adb from the granted requester (zero when idle).
REQ-020 SHALL treat the buffer read as 1-cycle latency: rd_valid[i] is high exactly one cycle after rd_gnt[i], and rd_data = mem_dout in that cycle.
REQ-021 SHALL hold rd_data at its last value when no rd_valid is high.
REQ-022 SHALL suppress all rd_gnt in any cycle where the winning read address equals the winning write address and a write is granted, so that read and write never hit the same address in one cycle.
REQ-023 SHALL leave the read pointer unchanged in such a hazard cycle, so the same requester wins on retry and sees the new data.
REQ-024 SHALL let requester i write and read in the same cycle when the addresses differ.
REQ-025 SHALL release a lock whose requester deasserts req for 16 consecutive cycles; a 4-bit idle counter per port implements this starvation guard.

Reset
REQ-026 SHALL, on reset, set both pointers to requester 0, clear both locks and idle counters, and set rd_valid to 0 and rd_data to 0.
REQ-027 SHALL force all grants, mem_cea and mem_ceb low during reset.
REQ-028 SHALL drop any read in flight if reset is asserted mid-operation, so no rd_valid follows.

Structure
REQ-029 SHALL place AW, DW, the requester count (2) and the idle-timeout constant (16) in the shared Kyber package.
REQ-030 SHALL implement the per-port round-robin/lock logic as one sub-module rr_lock_arb2, instantiated once for the write port and once for the read port.
REQ-031 SHALL contain no storage array; the 128x48 buffer stays external.

Verification
REQ-032 SHALL cover: both wr_req high at reset release, addr 5/6 -> cycle 1 grants wr 0 (addr 5), cycle 2 grants wr 1 (addr 6).
REQ-033 SHALL cover: rd_lock[1] held for 4 reads of addr 0..3 with rd_req[0] also high -> four consecutive rd_gnt[1], then rd_gnt[0].
REQ-034 SHALL cover: write addr 9 data 0xABCDEF012345 and read addr 9 in the same cycle -> rd_gnt low; next cycle rd_gnt high; rd_data = 0xABCDEF012345 one cycle later.
REQ-035 SHALL cover: read granted, then reset asserted next cycle -> rd_valid stays 0 and rd_data = 0.
REQ-036 SHALL cover: rd_lock[0] held with rd_req[0] low for 16 cycles and rd_req[1] high -> requester 1 is granted no later than cycle 17.
REQ-037 SHALL cover: requester 0 writes addr 3 while requester 1 reads addr 4 -> both grants high in the same cycle.

Source files
------------

// File: rtl/polymem_arbiter_pkg.sv
// Shared constants and types for the two-requester buffer arbiter.
package polymem_arbiter_pkg;

    localparam int unsigned MEM_AW       = 7;
    localparam int unsigned MEM_DW       = 48;
    localparam int unsigned NREQ         = 2;
    localparam int unsigned IDLE_TIMEOUT = 16;
    localparam int unsigned CNT_W        = 4;

    typedef logic [NREQ-1:0] req_vec_t;

    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/polymem_arbiter_if.sv
// Requester-side bus of the arbiter: write/read requests, grants and returned data.
interface polymem_arbiter_if
    import polymem_arbiter_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
);

    req_vec_t                   wr_req;
    req_vec_t                   wr_lock;
    logic [NREQ-1:0][AW-1:0]    wr_addr;
    logic [NREQ-1:0][DW-1:0]    wr_data;
    req_vec_t                   wr_gnt;

    req_vec_t                   rd_req;
    req_vec_t                   rd_lock;
    logic [NREQ-1:0][AW-1:0]    rd_addr;
    req_vec_t                   rd_gnt;
    req_vec_t                   rd_valid;
    logic [DW-1:0]              rd_data;

    modport master (
        output wr_req, wr_lock, wr_addr, wr_data, rd_req, rd_lock, rd_addr,
        input  wr_gnt, rd_gnt, rd_valid, rd_data
    );

    modport slave (
        input  wr_req, wr_lock, wr_addr, wr_data, rd_req, rd_lock, rd_addr,
        output wr_gnt, rd_gnt, rd_valid, rd_data
    );

endinterface

// File: rtl/polymem_arbiter_rr_lock_arb2.sv
// Two-way round-robin arbiter with burst lock and an idle-timeout release.
module rr_lock_arb2
    import polymem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  req_vec_t req,
    input  req_vec_t lock,
    input  logic     block,
    output req_vec_t gnt_c,
    output logic     cand_idx_c
);

    logic             ptr_q, ptr_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             cand_vld_c;
    logic             lock_hold_c;

    // A held lock keeps the other requester out even while the owner is idle.
    always_comb begin
        lock_hold_c = locked_q & lock[ptr_q];
        cand_vld_c  = 1'b0;
        cand_idx_c  = ptr_q;
        if (req[ptr_q]) begin
            cand_vld_c = 1'b1;
        end else if (req[other_req(ptr_q)] && !lock_hold_c) begin
            cand_vld_c = 1'b1;
            cand_idx_c = other_req(ptr_q);
        end
    end

    // Kept apart from the candidate logic so block may depend on cand_idx_c.
    always_comb begin
        gnt_c = '0;
        if (cand_vld_c && !block && !reset) begin
            gnt_c[cand_idx_c] = 1'b1;
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        locked_d = locked_q;
        idle_d   = idle_q;
        if (!block) begin
            if (cand_vld_c) begin
                idle_d   = '0;
                locked_d = lock[cand_idx_c];
                ptr_d    = lock[cand_idx_c] ? cand_idx_c : other_req(cand_idx_c);
            end else if (lock_hold_c) begin
                if (idle_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
                    locked_d = 1'b0;
                    idle_d   = '0;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end else begin
                locked_d = 1'b0;
                idle_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= 1'b0;
            locked_q <= 1'b0;
            idle_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            locked_q <= locked_d;
            idle_q   <= idle_d;
        end
    end

endmodule

// File: rtl/polymem_arbiter.sv
// Arbitrates two requesters onto the write and read ports of an external dual-port buffer.
module polymem_arbiter
    import polymem_arbiter_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
) (
    input  logic            clk,
    input  logic            reset,
    polymem_arbiter_if.slave bus,
    output logic            mem_cea,
    output logic [AW-1:0]   mem_ada,
    output logic [DW-1:0]   mem_din,
    output logic            mem_ceb,
    output logic            mem_oce,
    output logic [AW-1:0]   mem_adb,
    input  logic [DW-1:0]   mem_dout
);

    req_vec_t      wr_gnt_c, rd_gnt_c;
    req_vec_t      rd_valid_q, rd_valid_c;
    logic          wr_idx_c, rd_idx_c;
    logic          hazard_c;
    logic [DW-1:0] rd_data_q;

    rr_lock_arb2 u_wr_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (bus.wr_req),
        .lock       (bus.wr_lock),
        .block      (1'b0),
        .gnt_c      (wr_gnt_c),
        .cand_idx_c (wr_idx_c)
    );

    rr_lock_arb2 u_rd_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (bus.rd_req),
        .lock       (bus.rd_lock),
        .block      (hazard_c),
        .gnt_c      (rd_gnt_c),
        .cand_idx_c (rd_idx_c)
    );

    // A read colliding with this cycle's write waits one cycle and then sees the new word.
    always_comb begin
        hazard_c = (|wr_gnt_c) && (bus.wr_addr[wr_idx_c] == bus.rd_addr[rd_idx_c]);
    end

    always_comb begin
        mem_cea = |wr_gnt_c;
        mem_ada = '0;
        mem_din = '0;
        if (mem_cea) begin
            mem_ada = bus.wr_addr[wr_idx_c];
            mem_din = bus.wr_data[wr_idx_c];
        end
        mem_ceb = |rd_gnt_c;
        mem_oce = 1'b1;
        mem_adb = '0;
        if (mem_ceb) begin
            mem_adb = bus.rd_addr[rd_idx_c];
        end
        bus.wr_gnt = wr_gnt_c;
        bus.rd_gnt = rd_gnt_c;
    end

    // Reset squashes a read that is already in flight.
    always_comb begin
        rd_valid_c   = reset ? '0 : rd_valid_q;
        bus.rd_valid = rd_valid_c;
        bus.rd_data  = (|rd_valid_c) ? mem_dout : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_gnt_c;
            if (|rd_valid_c) begin
                rd_data_q <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_polymem_arbiter.sv
// Directed bench for polymem_arbiter with a behavioural 1-cycle-latency buffer.
module tb_polymem_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 48;
    localparam logic [DW-1:0] FILL = 48'hC0DE_0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_cea, mem_ceb, mem_oce;
    logic [AW-1:0] mem_ada, mem_adb;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] mem [128];
    logic [127:0]  seen;

    int vectors = 0;
    int miscompares = 0;

    polymem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    polymem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_cea  (mem_cea),
        .mem_ada  (mem_ada),
        .mem_din  (mem_din),
        .mem_ceb  (mem_ceb),
        .mem_oce  (mem_oce),
        .mem_adb  (mem_adb),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back as FILL + address.
    always @(posedge clk) begin
        if (reset) begin
            seen <= '0;
        end else if (mem_cea) begin
            mem[mem_ada]  <= mem_din;
            seen[mem_ada] <= 1'b1;
        end
        if (mem_ceb && mem_oce) begin
            mem_dout <= seen[mem_adb] ? mem[mem_adb] : (FILL | DW'(mem_adb));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.wr_req   = 2'b11;
        bus.wr_lock  = 2'b00;
        bus.wr_addr[0] = 7'd5;
        bus.wr_addr[1] = 7'd6;
        bus.wr_data[0] = 48'h1111_1111_1111;
        bus.wr_data[1] = 48'h2222_2222_2222;
        bus.rd_req   = 2'b00;
        bus.rd_lock  = 2'b00;
        bus.rd_addr[0] = 7'd0;
        bus.rd_addr[1] = 7'd0;

        step();
        step();
        @(negedge clk);
        check("rst_wr_gnt",   64'(bus.wr_gnt),   64'h0);
        check("rst_mem_cea",  64'(mem_cea),      64'h0);
        check("rst_mem_ceb",  64'(mem_ceb),      64'h0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
        check("rst_rd_data",  64'(bus.rd_data),  64'h0);
        check("rst_mem_oce",  64'(mem_oce),      64'h1);

        // Both writers pending at reset release: requester 0 first, then 1.
        step();
        reset = 1'b0;
        @(negedge clk);
        check("wr_c1_gnt", 64'(bus.wr_gnt), 64'h1);
        check("wr_c1_ada", 64'(mem_ada),    64'h5);
        check("wr_c1_din", 64'(mem_din),    64'h1111_1111_1111);
        step();
        @(negedge clk);
        check("wr_c2_gnt", 64'(bus.wr_gnt), 64'h2);
        check("wr_c2_ada", 64'(mem_ada),    64'h6);
        step();
        bus.wr_req = 2'b00;
        @(negedge clk);
        check("idle_cea", 64'(mem_cea), 64'h0);
        check("idle_ada", 64'(mem_ada), 64'h0);
        check("idle_din", 64'(mem_din), 64'h0);

        // Requester 0 writes addr 3 while requester 1 reads addr 4.
        step();
        bus.wr_req = 2'b01;
        bus.wr_addr[0] = 7'd3;
        bus.wr_data[0] = 48'h3333_3333_3333;
        bus.rd_req = 2'b10;
        bus.rd_addr[1] = 7'd4;
        @(negedge clk);
        check("par_wr_gnt", 64'(bus.wr_gnt), 64'h1);
        check("par_rd_gnt", 64'(bus.rd_gnt), 64'h2);
        check("par_adb",    64'(mem_adb),    64'h4);
        step();
        bus.wr_req = 2'b00;
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("par_rd_valid", 64'(bus.rd_valid), 64'h2);
        check("par_rd_data",  64'(bus.rd_data),  64'h0000_C0DE_0000_0004);
        step();
        @(negedge clk);
        check("hold_rd_valid", 64'(bus.rd_valid), 64'h0);
        check("hold_rd_data",  64'(bus.rd_data),  64'h0000_C0DE_0000_0004);

        // Same-address write and read: read deferred one cycle, pointer kept.
        step();
        bus.wr_req = 2'b01;
        bus.wr_addr[0] = 7'd9;
        bus.wr_data[0] = 48'hABCD_EF01_2345;
        bus.rd_req = 2'b11;
        bus.rd_addr[0] = 7'd9;
        bus.rd_addr[1] = 7'd20;
        @(negedge clk);
        check("haz_wr_gnt", 64'(bus.wr_gnt), 64'h1);
        check("haz_rd_gnt", 64'(bus.rd_gnt), 64'h0);
        check("haz_ceb",    64'(mem_ceb),    64'h0);
        step();
        bus.wr_req = 2'b00;
        @(negedge clk);
        check("haz_retry_gnt", 64'(bus.rd_gnt), 64'h1);
        check("haz_retry_adb", 64'(mem_adb),    64'h9);
        step();
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("haz_rd_valid", 64'(bus.rd_valid), 64'h1);
        check("haz_rd_data",  64'(bus.rd_data),  64'h0000_ABCD_EF01_2345);

        // Locked burst of four reads by requester 1 against a competing requester 0.
        bus.rd_addr[0] = 7'd50;
        for (int k = 0; k < 4; k++) begin
            step();
            bus.rd_req  = 2'b11;
            bus.rd_lock = 2'b10;
            bus.rd_addr[1] = AW'(k);
            @(negedge clk);
            check($sformatf("lock_gnt_%0d", k), 64'(bus.rd_gnt), 64'h2);
            check($sformatf("lock_adb_%0d", k), 64'(mem_adb), 64'(k));
            if (k == 1) begin
                check("lock_rd_data0", 64'(bus.rd_data), 64'h0000_C0DE_0000_0000);
            end
        end
        step();
        bus.rd_req  = 2'b01;
        bus.rd_lock = 2'b00;
        @(negedge clk);
        check("unlock_gnt", 64'(bus.rd_gnt), 64'h1);
        step();
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("unlock_rd_valid", 64'(bus.rd_valid), 64'h1);
        check("unlock_rd_data",  64'(bus.rd_data),  64'h0000_C0DE_0000_0032);

        // Requester 0 takes a lock and then goes idle; requester 1 must get through.
        step();
        bus.rd_req  = 2'b01;
        bus.rd_lock = 2'b01;
        @(negedge clk);
        check("starve_lock_gnt", 64'(bus.rd_gnt), 64'h1);
        for (int k = 1; k <= 17; k++) begin
            step();
            bus.rd_req = 2'b10;
            @(negedge clk);
            if (k == 1) begin
                check("starve_blocked", 64'(bus.rd_gnt), 64'h0);
            end
            if (k == 17) begin
                check("starve_release", 64'(bus.rd_gnt), 64'h2);
            end
        end

        // Read granted, then reset on the next cycle: the return is dropped.
        step();
        bus.rd_req  = 2'b01;
        bus.rd_lock = 2'b00;
        bus.rd_addr[0] = 7'd7;
        @(negedge clk);
        check("flight_gnt", 64'(bus.rd_gnt), 64'h1);
        step();
        reset = 1'b1;
        bus.rd_req = 2'b00;
        @(negedge clk);
        check("flight_rst_valid", 64'(bus.rd_valid), 64'h0);
        check("flight_rst_ceb",   64'(mem_ceb),      64'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("flight_post_valid", 64'(bus.rd_valid), 64'h0);
        check("flight_post_data",  64'(bus.rd_data),  64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
